// File: rtl/cache_ctrl.sv
// Sequencing controller for the direct-mapped write-back cacheBlock: power-up sweep,
// tag lookup, dirty write-back, line refill, partial-word stores and hit/miss statistics.
module cache_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_req,
    input  logic         cpu_wr,
    input  logic [31:0]  cpu_addr,
    input  logic [3:0]   cpu_be,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic         cpu_err,
    output logic         init_done,
    output logic [9:0]   Index,
    output logic [17:0]  Tag_In,
    output logic [3:0]   En_Word,
    output logic [3:0]   En_Byte,
    output logic         Wr,
    output logic         ValidNew,
    output logic         DirtyNew,
    output logic [127:0] Data_In,
    input  logic [17:0]  Tag_Out,
    input  logic         Valid_Out,
    input  logic         Dirty_Out,
    input  logic [127:0] Data_Out,
    output logic         mem_req,
    output logic         mem_wr,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ack,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOOKUP,
        WBACK,
        REFILL,
        ALLOC,
        RELOAD
    } state_t;

    state_t         state, next_state;
    logic [9:0]     sweep_cnt;
    logic           sweep_on;
    logic [17:0]    req_tag;
    logic [9:0]     req_index;
    logic [1:0]     req_word;
    logic           req_wr;
    logic [3:0]     req_be;
    logic [31:0]    req_wdata;
    logic [127:0]   wb_buf;
    logic [17:0]    wb_tag;
    logic [127:0]   fill_buf;
    logic           refilled;
    logic           hit;
    logic           be_legal;
    logic           store_bad;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];
    assign hit       = Valid_Out && (Tag_Out == req_tag);
    assign store_bad = req_wr && !be_legal;

    always_comb begin
        be_legal = 1'b0;
        case (req_be)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: be_legal = 1'b1;
            default:                            be_legal = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        cpu_rdata  = '0;
        cpu_ready  = 1'b0;
        cpu_err    = 1'b0;
        Index      = req_index;
        Tag_In     = '0;
        En_Word    = '0;
        En_Byte    = '0;
        Wr         = 1'b0;
        ValidNew   = 1'b0;
        DirtyNew   = 1'b0;
        Data_In    = '0;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            INIT: begin
                // sweep_on keeps the cacheBlock side quiet for the first cycle out of reset
                Index = sweep_cnt;
                if (sweep_on) begin
                    Wr      = 1'b1;
                    En_Word = '1;
                    En_Byte = '1;
                    if (sweep_cnt == '1) next_state = IDLE;
                end
            end
            IDLE: begin
                if (cpu_req) begin
                    Index      = cpu_addr[13:4];
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                if (store_bad) begin
                    cpu_ready  = 1'b1;
                    cpu_err    = 1'b1;
                    next_state = IDLE;
                end else if (hit) begin
                    cpu_ready  = 1'b1;
                    next_state = IDLE;
                    if (req_wr) begin
                        Wr       = 1'b1;
                        En_Word  = 4'b0001 << req_word;
                        En_Byte  = req_be;
                        Data_In  = {4{req_wdata}};
                        Tag_In   = req_tag;
                        ValidNew = 1'b1;
                        DirtyNew = 1'b1;
                    end else begin
                        cpu_rdata = Data_Out[{req_word, 5'd0} +: 32];
                    end
                end else if (Valid_Out && Dirty_Out) begin
                    next_state = WBACK;
                end else begin
                    next_state = REFILL;
                end
            end
            WBACK: begin
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {wb_tag, req_index, 4'b0000};
                mem_wdata = wb_buf;
                if (mem_ack) next_state = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_index, 4'b0000};
                if (mem_ack) next_state = ALLOC;
            end
            ALLOC: begin
                Wr         = 1'b1;
                En_Word    = '1;
                En_Byte    = '1;
                Data_In    = fill_buf;
                Tag_In     = req_tag;
                ValidNew   = 1'b1;
                next_state = RELOAD;
            end
            RELOAD: begin
                next_state = LOOKUP;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
            sweep_on  <= 1'b0;
            init_done <= 1'b0;
            req_tag   <= '0;
            req_index <= '0;
            req_word  <= '0;
            req_wr    <= 1'b0;
            req_be    <= '0;
            req_wdata <= '0;
            wb_buf    <= '0;
            wb_tag    <= '0;
            fill_buf  <= '0;
            refilled  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == INIT) begin
                sweep_on <= 1'b1;
                if (sweep_on) begin
                    sweep_cnt <= sweep_cnt + 10'd1;
                    if (sweep_cnt == '1) init_done <= 1'b1;
                end
            end
            if (state == IDLE && cpu_req) begin
                req_tag   <= cpu_addr[31:14];
                req_index <= cpu_addr[13:4];
                req_word  <= cpu_addr[3:2];
                req_wr    <= cpu_wr;
                req_be    <= cpu_be;
                req_wdata <= cpu_wdata;
                refilled  <= 1'b0;
            end
            if (state == LOOKUP && !store_bad && !hit && Valid_Out && Dirty_Out) begin
                wb_buf <= Data_Out;
                wb_tag <= Tag_Out;
            end
            if (state == REFILL && mem_ack) fill_buf <= mem_rdata;
            if (state == RELOAD) refilled <= 1'b1;
        end
    end

    // Only the first lookup of a request is counted; the post-refill lookup is not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP && !store_bad && !refilled) begin
            if (hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 16'd1;
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cacheBlock and memory, flat-memory reference model,
// directed scenarios followed by randomized loads/stores.
module tb_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]   cpu_be = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready, cpu_err, init_done;
    logic [9:0]   Index;
    logic [17:0]  Tag_In, Tag_Out;
    logic [3:0]   En_Word, En_Byte;
    logic         Wr, ValidNew, DirtyNew, Valid_Out, Dirty_Out;
    logic [127:0] Data_In, Data_Out;
    logic         mem_req, mem_wr;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;
    logic [15:0]  hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cpu_err(cpu_err), .init_done(init_done), .Index(Index), .Tag_In(Tag_In),
        .En_Word(En_Word), .En_Byte(En_Byte), .Wr(Wr), .ValidNew(ValidNew), .DirtyNew(DirtyNew),
        .Data_In(Data_In), .Tag_Out(Tag_Out), .Valid_Out(Valid_Out), .Dirty_Out(Dirty_Out),
        .Data_Out(Data_Out), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // cacheBlock: one-cycle registered read, byte-masked write
    logic [17:0]  cb_tag   [1024];
    logic         cb_valid [1024];
    logic         cb_dirty [1024];
    logic [127:0] cb_data  [1024];

    always @(posedge clk) begin
        Tag_Out   <= cb_tag[Index];
        Valid_Out <= cb_valid[Index];
        Dirty_Out <= cb_dirty[Index];
        Data_Out  <= cb_data[Index];
        if (Wr) begin
            for (int w = 0; w < 4; w++)
                for (int b = 0; b < 4; b++)
                    if (En_Word[w] && En_Byte[b])
                        cb_data[Index][w*32 + b*8 +: 8] <= Data_In[w*32 + b*8 +: 8];
            cb_tag[Index]   <= Tag_In;
            cb_valid[Index] <= ValidNew;
            cb_dirty[Index] <= DirtyNew;
        end
    end

    int tests = 0;
    int fails = 0;

    logic [127:0] bmem    [logic [27:0]];
    logic [31:0]  ref_mem [logic [29:0]];
    bit           m_valid [1024];
    bit           m_dirty [1024];
    logic [17:0]  m_tag   [1024];
    logic [15:0]  exp_hit = '0, exp_miss = '0;

    logic [31:0]  r_rdata, r_ack_addr [3], r_follow_addr [3];
    logic [127:0] r_ack_data [3], r_din;
    logic         r_ack_wr [3], r_follow_req [3], r_follow_wr [3];
    logic         r_err, r_rdy_wr, r_dn, r_saw_wr, r_saw_mreq, r_unstable, r_done;
    logic [3:0]   r_enw, r_enb;
    int           r_lat, r_acks, r_ack_to_ready;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] base_word(input logic [31:0] a);
        if (a[31:4] == 28'h1) return 32'h1111_1111 * (32'(a[3:2]) + 32'd1);
        return {a[31:2], 2'b00} ^ 32'hC3A5_0F00;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        logic [31:0] la;
        la = {a[31:4], 4'b0000};
        if (bmem.exists(a[31:4])) return bmem[a[31:4]];
        return {base_word(la + 12), base_word(la + 8), base_word(la + 4), base_word(la)};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [127:0] l;
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        l = mem_line(a);
        return l[{a[3:2], 5'd0} +: 32];
    endfunction

    // Issues one request and plays the memory side; results land in the r_* variables.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd);
        bit           active;
        int unsigned  wait_n;
        int           last_ack;
        logic [160:0] cap;
        active = 0; wait_n = 0; last_ack = -100; cap = '0;
        r_done = 0; r_acks = 0; r_lat = 0; r_saw_wr = 0; r_saw_mreq = 0; r_unstable = 0;
        r_ack_to_ready = 0;
        for (int i = 0; i < 3; i++) begin
            r_follow_req[i] = 1'bx; r_follow_wr[i] = 1'bx; r_follow_addr[i] = 'x;
        end
        cpu_req = 1; cpu_wr = wr; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
        for (int cyc = 1; cyc <= 300 && !r_done; cyc++) begin
            @(negedge clk);
            mem_ack = 0;
            if (cyc == last_ack + 1 && r_acks >= 1 && r_acks <= 3) begin
                r_follow_req[r_acks-1]  = mem_req;
                r_follow_wr[r_acks-1]   = mem_wr;
                r_follow_addr[r_acks-1] = mem_addr;
            end
            if (cpu_ready) begin
                r_done = 1; r_lat = cyc; r_ack_to_ready = cyc - last_ack;
                r_rdata = cpu_rdata; r_err = cpu_err; r_rdy_wr = Wr; r_enw = En_Word;
                r_enb = En_Byte; r_dn = DirtyNew; r_din = Data_In;
            end else if (Wr) begin
                r_saw_wr = 1;
            end
            if (mem_req) begin
                r_saw_mreq = 1;
                if (!active) begin
                    active = 1; cap = {mem_wr, mem_addr, mem_wdata};
                    wait_n = $urandom_range(0, 3);
                end else if ({mem_wr, mem_addr, mem_wdata} !== cap) begin
                    r_unstable = 1;
                end
                if (wait_n == 0) begin
                    if (r_acks < 3) begin
                        r_ack_wr[r_acks] = mem_wr; r_ack_addr[r_acks] = mem_addr;
                        r_ack_data[r_acks] = mem_wdata;
                    end
                    if (mem_wr) bmem[mem_addr[31:4]] = mem_wdata;
                    else mem_rdata = mem_line(mem_addr);
                    mem_ack = 1; active = 0; r_acks++; last_ack = cyc;
                end else begin
                    wait_n--;
                end
            end
        end
        cpu_req = 0; mem_ack = 0;
        chk("req_done", r_done, 1);
        @(negedge clk);
    endtask

    task automatic txn(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
        logic [9:0]   idx;
        logic [17:0]  tag;
        logic [31:0]  victim, exp_rd, nw;
        logic [127:0] victim_line;
        bit           legal, hit, dirty_victim;
        int           exp_acks;
        idx = addr[13:4]; tag = addr[31:14];
        legal = be inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        if (wr && !legal) begin
            do_req(wr, addr, be, wd);
            chk("bad_be_err", r_err, 1);
            chk("bad_be_lat", r_lat, 1);
            chk("bad_be_wr", r_saw_wr | r_rdy_wr, 0);
            chk("bad_be_mreq", r_saw_mreq, 0);
            chk("bad_be_hits", hit_cnt, exp_hit);
            chk("bad_be_miss", miss_cnt, exp_miss);
            return;
        end
        hit = m_valid[idx] && (m_tag[idx] == tag);
        dirty_victim = !hit && m_valid[idx] && m_dirty[idx];
        victim = {m_tag[idx], idx, 4'b0000};
        victim_line = {ref_word(victim + 12), ref_word(victim + 8),
                       ref_word(victim + 4), ref_word(victim)};
        exp_rd = ref_word(addr);
        if (hit) begin
            if (exp_hit != 16'hFFFF) exp_hit++;
        end else begin
            if (exp_miss != 16'hFFFF) exp_miss++;
        end
        exp_acks = hit ? 0 : (dirty_victim ? 2 : 1);
        do_req(wr, addr, be, wd);
        chk("err", r_err, 0);
        chk("mem_acks", r_acks, exp_acks);
        chk("hit_cnt", hit_cnt, exp_hit);
        chk("miss_cnt", miss_cnt, exp_miss);
        chk("mem_stable", r_unstable, 0);
        if (hit) chk("hit_lat", r_lat, 1);
        else begin
            chk("ack_to_ready", r_ack_to_ready, 3);
            chk("refill_addr", r_ack_addr[exp_acks-1], {tag, idx, 4'b0000});
            chk("refill_wr", r_ack_wr[exp_acks-1], 0);
            chk("req_after_last_ack", r_follow_req[exp_acks-1], 0);
        end
        if (exp_acks == 2) begin
            chk("wb_wr", r_ack_wr[0], 1);
            chk("wb_addr", r_ack_addr[0], victim);
            chk("wb_data", r_ack_data[0], victim_line);
            chk("wb_to_refill_req", r_follow_req[0], 1);
            chk("wb_to_refill_addr", {r_follow_wr[0], r_follow_addr[0]}, {1'b0, tag, idx, 4'b0000});
        end
        if (!wr) begin
            chk("rdata", r_rdata, exp_rd);
            chk("load_no_wr", r_rdy_wr, 0);
        end else begin
            chk("st_wr", r_rdy_wr, 1);
            chk("st_en_word", r_enw, 4'b0001 << addr[3:2]);
            chk("st_en_byte", r_enb, be);
            chk("st_dirty", r_dn, 1);
            chk("st_data", r_din, {4{wd}});
        end
        m_valid[idx] = 1; m_tag[idx] = tag;
        if (!hit) m_dirty[idx] = 0;
        if (wr) begin
            m_dirty[idx] = 1;
            nw = exp_rd;
            for (int b = 0; b < 4; b++) if (be[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[addr[31:2]] = nw;
        end
    endtask

    task automatic sweep_check(input bit poke_req);
        int cnt, bad, last_wr, gap;
        cnt = 0; bad = 0; last_wr = -100; gap = -1;
        if (poke_req) begin
            cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h0000_0010; cpu_be = '1; cpu_wdata = '1;
        end
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (init_done) begin gap = c - last_wr; break; end
            if (Wr) begin
                if (Index !== cnt[9:0] || ValidNew || DirtyNew || En_Word !== 4'hF ||
                    En_Byte !== 4'hF) bad++;
                cnt++; last_wr = c;
            end
        end
        cpu_req = 0;
        chk("sweep_count", cnt, 1024);
        chk("sweep_fields", bad, 0);
        chk("init_done", init_done, 1);
        chk("init_done_gap", gap, 1);
        for (int i = 0; i < 1024; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        exp_hit = '0; exp_miss = '0;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  be;
        bit          got;
        logic [3:0]  legal_be [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
        logic [3:0]  bad_be   [6] = '{4'h0, 4'h5, 4'h6, 4'hA, 4'hE, 4'h7};

        repeat (3) @(negedge clk);
        chk("rst_wr", Wr, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ready", cpu_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_counts", {hit_cnt, miss_cnt}, 0);
        rst_n = 1;
        sweep_check(1);

        txn(0, 32'h0000_0010, 4'hF, 0);
        chk("cold_rdata", r_rdata, 32'h1111_1111);
        chk("cold_miss_cnt", miss_cnt, 1);
        chk("cold_refill_addr", r_ack_addr[0], 32'h0000_0010);
        txn(0, 32'h0000_0014, 4'hF, 0);
        chk("warm_rdata", r_rdata, 32'h2222_2222);
        chk("warm_hit_cnt", hit_cnt, 1);
        txn(1, 32'h0000_0018, 4'b0100, 32'hAABB_CCDD);
        chk("store_en", {r_enw, r_enb, r_dn}, {4'b0100, 4'b0100, 1'b1});
        txn(0, 32'h0000_0018, 4'hF, 0);
        chk("store_rdback", r_rdata, 32'h33BB_3333);
        txn(0, 32'h0000_4010, 4'hF, 0);
        chk("evict_wb_addr", r_ack_addr[0], 32'h0000_0010);
        chk("evict_wb_data", r_ack_data[0], 128'h4444_4444_33BB_3333_2222_2222_1111_1111);
        chk("evict_refill_addr", r_ack_addr[1], 32'h0000_4010);
        txn(1, 32'h0000_4010, 4'b0101, 32'h1234_5678);

        for (int n = 0; n < 160; n++) begin
            a = {16'h0, 2'($urandom_range(0, 3)), 7'h0, 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 2'b00};
            be = ($urandom_range(0, 7) == 0) ? bad_be[$urandom_range(0, 5)]
                                             : legal_be[$urandom_range(0, 6)];
            txn($urandom_range(0, 1) == 1, a, be, $urandom);
        end

        txn(0, 32'h0000_0024, 4'hF, 0);
        force dut.hit_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt;
        @(negedge clk);
        chk("sat_forced", hit_cnt, 16'hFFFF);
        exp_hit = 16'hFFFF;
        txn(0, 32'h0000_0024, 4'hF, 0);
        chk("sat_hold", hit_cnt, 16'hFFFF);

        cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h0008_0200; cpu_be = '1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (mem_req && !mem_wr) got = 1;
        end
        chk("mid_reach_refill", got, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_ready", cpu_ready, 0);
        chk("mid_rst_wr", Wr, 0);
        cpu_req = 0;
        for (int i = 0; i < 1024; i++)
            if (m_valid[i] && m_dirty[i])
                for (int w = 0; w < 4; w++) begin
                    a = {m_tag[i], 10'(i), 2'(w), 2'b00};
                    if (ref_mem.exists(a[31:2])) ref_mem.delete(a[31:2]);
                end
        @(negedge clk);
        chk("mid_rst_counts", {hit_cnt, miss_cnt, init_done}, 0);
        rst_n = 1;
        sweep_check(0);
        for (int n = 0; n < 30; n++) begin
            a = {16'h0, 2'($urandom_range(0, 3)), 7'h0, 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 2'b00};
            txn($urandom_range(0, 1) == 1, a, legal_be[$urandom_range(0, 6)], $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
